// File: rtl/iob_skid_reg.sv
// iob_skid_reg: two-entry skid buffer between a valid/ready producer and consumer.
// The main register always drives out_data; the skid register catches the one
// word that arrives while the consumer is stalled, so in_ready and out_valid
// can both come straight from flops without any combinational ready path.
module iob_skid_reg #(
    parameter int                 DATA_W  = 32,
    parameter logic [DATA_W-1:0]  RST_VAL = '0
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [1:0]        level
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state_q,     state_d;
    logic [DATA_W-1:0] main_q,      main_d;
    logic [DATA_W-1:0] skid_q,      skid_d;
    logic              in_ready_q,  in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [1:0]        level_q,     level_d;

    logic in_xfer;
    logic out_xfer;

    // Handshakes use only the registered ready/valid flags on our side.
    assign in_xfer  = in_valid & in_ready_q;
    assign out_xfer = out_valid_q & out_ready;

    // Next state and data movement; the synchronous clear overrides any transfer.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    main_d  = in_data;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    // Outgoing word leaves as the new one replaces it.
                    main_d  = in_data;
                end else if (in_xfer) begin
                    skid_d  = in_data;
                    state_d = FULL;
                end else if (out_xfer) begin
                    // main keeps its value so out_data holds while empty.
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_xfer) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase

        if (rst) begin
            state_d = EMPTY;
            main_d  = RST_VAL;
            skid_d  = RST_VAL;
        end
    end

    // Output flags are precomputed from the next state so they are pure flop outputs.
    always_comb begin
        in_ready_d  = (state_d != FULL);
        out_valid_d = (state_d != EMPTY);
        level_d     = 2'd0;
        case (state_d)
            EMPTY:   level_d = 2'd0;
            ONE:     level_d = 2'd1;
            FULL:    level_d = 2'd2;
            default: level_d = 2'd0;
        endcase
    end

    // State, data and flag registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= EMPTY;
            main_q      <= RST_VAL;
            skid_q      <= RST_VAL;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            level_q     <= 2'd0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            level_q     <= level_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;
    assign level     = level_q;

endmodule

// File: tb/tb_iob_skid_reg.sv
// Bench for iob_skid_reg (DATA_W=8, RST_VAL=8'hA5): directed scenario tasks plus
// a scoreboard monitor that tracks every accepted word and every stall.
module tb_iob_skid_reg;

    localparam int          DW   = 8;
    localparam logic [7:0]  RSTV = 8'hA5;

    logic          clk;
    logic          arst_n;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic [1:0]    level;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    logic [DW-1:0] sb[$];
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data  = '0;
    logic [DW-1:0] exp_word;

    iob_skid_reg #(.DATA_W(DW), .RST_VAL(RSTV)) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .level     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: at each falling edge, record what the next rising edge will transfer.
    always @(negedge clk) begin
        if (!arst_n || rst) begin
            sb.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                assert_cnt++;
                if (out_valid !== 1'b1 || out_data !== prev_data) begin
                    fail_cnt++;
                    $display("FAIL stall_hold: out_valid=%b out_data=%h required out_valid=1 out_data=%h",
                             out_valid, out_data, prev_data);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                assert_cnt++;
                if (sb.size() == 0) begin
                    fail_cnt++;
                    $display("FAIL sb_underflow: out_data=%h emitted with no word outstanding", out_data);
                end else begin
                    exp_word = sb.pop_front();
                    if (out_data !== exp_word) begin
                        fail_cnt++;
                        $display("FAIL sb_order: out_data=%h required %h", out_data, exp_word);
                    end
                end
            end
            if (in_valid === 1'b1 && in_ready === 1'b1) sb.push_back(in_data);
            prev_stall = (out_valid === 1'b1) && (out_ready !== 1'b1);
            prev_data  = out_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        arst_n = 1'b0; rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #12;
        assert_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || level !== 2'd0 || out_data !== RSTV) begin
            fail_cnt++;
            $display("FAIL reset_hold: ov=%b ir=%b lvl=%0d od=%h required ov=0 ir=1 lvl=0 od=%h",
                     out_valid, in_ready, level, out_data, RSTV);
        end
        @(negedge clk);
        arst_n = 1'b1;
        tick();
        tick();
        assert_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || level !== 2'd0 || out_data !== RSTV) begin
            fail_cnt++;
            $display("FAIL reset_release: ov=%b ir=%b lvl=%0d od=%h required ov=0 ir=1 lvl=0 od=%h",
                     out_valid, in_ready, level, out_data, RSTV);
        end
        $display("test_reset done");
    endtask

    task automatic test_streaming();
        logic [7:0] w;
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            w = 8'(i);
            in_valid = 1'b1; in_data = w;
            tick();
            assert_cnt++;
            if (out_valid !== 1'b1 || out_data !== w || level !== 2'd1 || in_ready !== 1'b1) begin
                fail_cnt++;
                $display("FAIL stream_%0d: ov=%b od=%h lvl=%0d ir=%b required ov=1 od=%h lvl=1 ir=1",
                         i, out_valid, out_data, level, in_ready, w);
            end
        end
        in_valid = 1'b0;
        tick();
        assert_cnt++;
        if (out_valid !== 1'b0 || level !== 2'd0 || out_data !== 8'h10) begin
            fail_cnt++;
            $display("FAIL stream_drain: ov=%b lvl=%0d od=%h required ov=0 lvl=0 od=10",
                     out_valid, level, out_data);
        end
        $display("test_streaming done");
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h11;
        tick();
        in_data = 8'h22;
        tick();
        in_valid = 1'b0;
        assert_cnt++;
        if (level !== 2'd2 || in_ready !== 1'b0 || out_data !== 8'h11 || out_valid !== 1'b1) begin
            fail_cnt++;
            $display("FAIL bp_full: lvl=%0d ir=%b od=%h ov=%b required lvl=2 ir=0 od=11 ov=1",
                     level, in_ready, out_data, out_valid);
        end
        tick();
        assert_cnt++;
        if (level !== 2'd2 || out_data !== 8'h11) begin
            fail_cnt++;
            $display("FAIL bp_hold: lvl=%0d od=%h required lvl=2 od=11", level, out_data);
        end
        out_ready = 1'b1;
        tick();
        assert_cnt++;
        if (in_ready !== 1'b1 || level !== 2'd1 || out_data !== 8'h22) begin
            fail_cnt++;
            $display("FAIL bp_first_out: ir=%b lvl=%0d od=%h required ir=1 lvl=1 od=22",
                     in_ready, level, out_data);
        end
        tick();
        assert_cnt++;
        if (level !== 2'd0 || out_valid !== 1'b0) begin
            fail_cnt++;
            $display("FAIL bp_drain: lvl=%0d ov=%b required lvl=0 ov=0", level, out_valid);
        end
        out_ready = 1'b0;
        $display("test_backpressure done");
    endtask

    task automatic test_simultaneous();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h33;
        tick();
        in_valid = 1'b0;
        tick();
        assert_cnt++;
        if (out_data !== 8'h33 || level !== 2'd1) begin
            fail_cnt++;
            $display("FAIL simul_hold: od=%h lvl=%0d required od=33 lvl=1", out_data, level);
        end
        in_valid = 1'b1; in_data = 8'h44; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        assert_cnt++;
        if (out_data !== 8'h44 || level !== 2'd1 || out_valid !== 1'b1) begin
            fail_cnt++;
            $display("FAIL simul_swap: od=%h lvl=%0d ov=%b required od=44 lvl=1 ov=1",
                     out_data, level, out_valid);
        end
        tick();
        out_ready = 1'b0;
        $display("test_simultaneous done");
    endtask

    task automatic test_clear();
        // Synchronous clear from FULL with a competing input word.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h55;
        tick();
        in_data = 8'h66;
        tick();
        assert_cnt++;
        if (level !== 2'd2) begin
            fail_cnt++;
            $display("FAIL clr_fill: lvl=%0d required 2", level);
        end
        rst = 1'b1; in_data = 8'h77;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        assert_cnt++;
        if (level !== 2'd0 || out_valid !== 1'b0 || out_data !== RSTV || in_ready !== 1'b1) begin
            fail_cnt++;
            $display("FAIL sync_clear: lvl=%0d ov=%b od=%h ir=%b required lvl=0 ov=0 od=%h ir=1",
                     level, out_valid, out_data, in_ready, RSTV);
        end
        out_ready = 1'b1;
        tick();
        tick();
        assert_cnt++;
        if (out_valid !== 1'b0 || level !== 2'd0) begin
            fail_cnt++;
            $display("FAIL sync_clear_drop: ov=%b lvl=%0d required ov=0 lvl=0", out_valid, level);
        end
        // Asynchronous clear from FULL, observed immediately.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h88;
        tick();
        in_data = 8'h99;
        tick();
        arst_n = 1'b0;
        #1;
        assert_cnt++;
        if (level !== 2'd0 || out_valid !== 1'b0 || out_data !== RSTV || in_ready !== 1'b1) begin
            fail_cnt++;
            $display("FAIL async_clear: lvl=%0d ov=%b od=%h ir=%b required lvl=0 ov=0 od=%h ir=1",
                     level, out_valid, out_data, in_ready, RSTV);
        end
        tick();
        arst_n = 1'b1; in_valid = 1'b0;
        tick();
        assert_cnt++;
        if (level !== 2'd0 || out_valid !== 1'b0 || out_data !== RSTV) begin
            fail_cnt++;
            $display("FAIL async_release: lvl=%0d ov=%b od=%h required lvl=0 ov=0 od=%h",
                     level, out_valid, out_data, RSTV);
        end
        $display("test_clear done");
    endtask

    task automatic test_random();
        int budget;
        for (int c = 0; c < 10000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_data   = 8'($urandom);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        budget = 0;
        while (level !== 2'd0 && budget < 10) begin
            tick();
            budget++;
        end
        tick();
        assert_cnt++;
        if (level !== 2'd0 || sb.size() != 0) begin
            fail_cnt++;
            $display("FAIL random_drain: lvl=%0d outstanding=%0d required lvl=0 outstanding=0",
                     level, sb.size());
        end
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_simultaneous();
        test_clear();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/iob_skid_reg.md
IOB_SKID_REG -- requirements
Module: iob_skid_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the payload width in bits (minimum 1).
REQ-002 The block SHALL have parameter RST_VAL, default 0, giving the reset value of both data registers, truncated or zero-extended to DATA_W.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port arst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous active-high clear.
REQ-006 The block SHALL have port in_valid, input, 1 bit: upstream word present.
REQ-007 The block SHALL have port in_data, input, DATA_W bits: upstream word.
REQ-008 The block SHALL have port in_ready, output, 1 bit: block accepts a word this cycle.
REQ-009 The block SHALL have port out_valid, output, 1 bit: downstream word present.
REQ-010 The block SHALL have port out_data, output, DATA_W bits: downstream word.
REQ-011 The block SHALL have port out_ready, input, 1 bit: downstream accepts.
REQ-012 The block SHALL have port level, output, 2 bits: number of words held (0..2).

Function
REQ-013 The block SHALL hold a main register (drives out_data) and a skid register, and SHALL use states EMPTY (level 0), ONE (level 1, main valid) and FULL (level 2, main and skid valid).
REQ-014 An input transfer SHALL occur when in_valid and in_ready are both 1 at a rising edge; an output transfer SHALL occur when out_valid and out_ready are both 1 at a rising edge.
REQ-015 in_ready SHALL be 1 exactly when state is not FULL, out_valid SHALL be 1 exactly when state is not EMPTY, and both SHALL be driven from registers with no combinational path from in_valid or out_ready.
REQ-016 In EMPTY, an input transfer SHALL load main with in_data and go to ONE; otherwise the block SHALL stay in EMPTY.
REQ-017 In ONE, simultaneous input and output transfers SHALL load main with in_data and stay in ONE.
REQ-018 In ONE, an input transfer alone SHALL load skid with in_data and go to FULL.
REQ-019 In ONE, an output transfer alone SHALL go to EMPTY.
REQ-020 In FULL, an output transfer SHALL move skid into main and go to ONE; otherwise the block SHALL hold.
REQ-021 Latency from input transfer to out_valid SHALL be exactly 1 cycle when EMPTY; sustained throughput with out_ready held at 1 SHALL be one word per cycle.
REQ-022 Words SHALL leave in acceptance order, with no loss and no duplication.
REQ-023 out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-024 While EMPTY, out_data SHALL hold the last value of main.

Reset
REQ-025 While arst_n=0, the block SHALL be EMPTY with main=skid=RST_VAL, out_valid=0, in_ready=1, level=0 and out_data=RST_VAL.
REQ-026 rst=1 at a rising edge SHALL produce the same state as REQ-025, SHALL take priority over any transfer that cycle, and SHALL discard all held words.
REQ-027 Deassertion of arst_n SHALL take effect at the next rising edge with no glitch on outputs.

Verification
REQ-028 Reset check: with DATA_W=8 and RST_VAL=8'hA5, hold arst_n=0, then release -> out_valid=0, in_ready=1, level=0, out_data=8'hA5.
REQ-029 Streaming check: out_ready=1 throughout; present 0x01..0x10 on consecutive cycles -> same sequence on out_data, each word one cycle later, no bubbles, level stays 1.
REQ-030 Backpressure check: out_ready=0; send 0x11 then 0x22 -> level=2 and in_ready=0 after the second word; raise out_ready -> 0x11 then 0x22 emerge, and in_ready=1 the cycle after the first output transfer.
REQ-031 Simultaneous transfers in ONE: hold 0x33, then in_valid=1 with 0x44 and out_ready=1 -> 0x33 transfers, out_data=0x44 next cycle, level stays 1.
REQ-032 Mid-operation clears: in FULL, assert rst for one cycle with in_valid=1 -> level=0, out_valid=0, out_data=RST_VAL, input word not accepted; repeat using arst_n pulse -> same result immediately.
REQ-033 Random check: random in_valid and out_ready over 10k cycles -> scoreboard shows in-order, lossless transfer and out_data stable under stall.
